serial_subtractor: RTL and testbench

//   Bit-serial two's-complement subtractor computing D = A - B - b_in, one bit per clock, LSB first.
//   It is the inverse arithmetic counterpart of the 4-bit ripple-carry adder on the SW/LEDR lab board.
//   A single full-subtractor cell is reused WIDTH times, with the borrow held in a flip-flop.
//   A start/busy/done handshake lets a top-level wrapper drive it from switches/keys and show D on LEDs.

---
 rtl/serial_subtractor.sv | 126 ++++++++++++
 tb/tb_serial_subtractor.sv | 244 ++++++++++++++++++++++++
 2 files changed

// File: rtl/serial_subtractor.sv
// Bit-serial two's-complement subtractor: D = A - B - b_in, one bit per clock, LSB first.
// One full-subtractor cell is reused WIDTH times with the borrow carried in a flop.
module serial_subtractor #(
   parameter int WIDTH = 4
) (
   input  logic             clock,
   input  logic             reset,
   input  logic             start,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             b_in,
   output logic [WIDTH-1:0] d,
   output logic             b_out,
   output logic             overflow,
   output logic             busy,
   output logic             done
);

   localparam int CW = $clog2(WIDTH) + 1;
   localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);
   localparam logic [CW-1:0] CNT_MSB_IN = CW'(WIDTH - 2);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_e;

   state_e           state_q, state_d;
   logic [WIDTH-1:0] sa_q, sa_d;
   logic [WIDTH-1:0] sb_q, sb_d;
   logic [WIDTH-1:0] acc_q, acc_d;
   logic [CW-1:0]    cnt_q, cnt_d;
   logic             borrow_q, borrow_d;
   logic             msb_bin_q, msb_bin_d;
   logic [WIDTH-1:0] d_q, d_d;
   logic             b_out_q, b_out_d;
   logic             overflow_q, overflow_d;

   logic x, y, w, dbit, borrow_nxt;

   always_comb begin
      x          = sa_q[0];
      y          = sb_q[0];
      w          = borrow_q;
      dbit       = x ^ y ^ w;
      borrow_nxt = (~x & y) | (~x & w) | (y & w);

      state_d    = state_q;
      sa_d       = sa_q;
      sb_d       = sb_q;
      acc_d      = acc_q;
      cnt_d      = cnt_q;
      borrow_d   = borrow_q;
      msb_bin_d  = msb_bin_q;
      d_d        = d_q;
      b_out_d    = b_out_q;
      overflow_d = overflow_q;

      case (state_q)
         IDLE, DONE: begin
            // DONE accepts a new request directly so back-to-back ops cost no idle cycle.
            if (start) begin
               state_d  = RUN;
               sa_d     = a;
               sb_d     = b;
               borrow_d = b_in;
               cnt_d    = '0;
               acc_d    = '0;
            end else begin
               state_d = IDLE;
            end
         end
         RUN: begin
            borrow_d = borrow_nxt;
            acc_d    = {dbit, acc_q[WIDTH-1:1]};
            sa_d     = sa_q >> 1;
            sb_d     = sb_q >> 1;
            cnt_d    = cnt_q + CW'(1);
            if (cnt_q == CNT_MSB_IN) begin
               msb_bin_d = borrow_nxt;
            end
            if (cnt_q == CNT_LAST) begin
               d_d        = {dbit, acc_q[WIDTH-1:1]};
               b_out_d    = borrow_nxt;
               overflow_d = msb_bin_q ^ borrow_nxt;
               state_d    = DONE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         state_q    <= IDLE;
         sa_q       <= '0;
         sb_q       <= '0;
         acc_q      <= '0;
         cnt_q      <= '0;
         borrow_q   <= 1'b0;
         msb_bin_q  <= 1'b0;
         d_q        <= '0;
         b_out_q    <= 1'b0;
         overflow_q <= 1'b0;
      end else begin
         state_q    <= state_d;
         sa_q       <= sa_d;
         sb_q       <= sb_d;
         acc_q      <= acc_d;
         cnt_q      <= cnt_d;
         borrow_q   <= borrow_d;
         msb_bin_q  <= msb_bin_d;
         d_q        <= d_d;
         b_out_q    <= b_out_d;
         overflow_q <= overflow_d;
      end
   end

   assign d        = d_q;
   assign b_out    = b_out_q;
   assign overflow = overflow_q;
   assign busy     = (state_q == RUN);
   assign done     = (state_q == DONE);

endmodule

// File: tb/tb_serial_subtractor.sv
// Directed bench for serial_subtractor (WIDTH=4): vector table, multi-cycle corner
// sequences and a full operand sweep against an arithmetic reference model.
module tb_serial_subtractor;

   localparam int WIDTH = 4;

   logic             clock;
   logic             reset;
   logic             start;
   logic [WIDTH-1:0] a;
   logic [WIDTH-1:0] b;
   logic             b_in;
   logic [WIDTH-1:0] d;
   logic             b_out;
   logic             overflow;
   logic             busy;
   logic             done;

   int checks;
   int failures;

   typedef struct {
      logic [3:0] a;
      logic [3:0] b;
      logic       bin;
      logic [3:0] d;
      logic       bo;
      logic       ov;
   } vec_t;

   vec_t vecs[6];

   serial_subtractor #(.WIDTH(WIDTH)) dut (
      .clock    (clock),
      .reset    (reset),
      .start    (start),
      .a        (a),
      .b        (b),
      .b_in     (b_in),
      .d        (d),
      .b_out    (b_out),
      .overflow (overflow),
      .busy     (busy),
      .done     (done)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   task automatic check(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         failures++;
         $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
      end
   endtask

   // Arithmetic reference: unsigned difference for d/b_out, signed range test for overflow.
   task automatic model(input int ai, input int bi, input int bini,
                        output int ed, output int ebo, output int eov);
      int diff, sa, sb, sd;
      diff = ai - bi - bini;
      ed   = diff & 15;
      ebo  = (diff < 0) ? 1 : 0;
      sa   = (ai >= 8) ? ai - 16 : ai;
      sb   = (bi >= 8) ? bi - 16 : bi;
      sd   = sa - sb - bini;
      eov  = (sd > 7 || sd < -8) ? 1 : 0;
   endtask

   // Aligns to a posedge, presents a request, returns 1ns after the accepting edge.
   task automatic start_op(input logic [3:0] ai, input logic [3:0] bi, input logic bini);
      @(posedge clock);
      #1;
      a     = ai;
      b     = bi;
      b_in  = bini;
      start = 1'b1;
      @(posedge clock);
      #1;
      start = 1'b0;
   endtask

   // Counts negedges without done (bounded); returns sitting on the negedge where done=1.
   task automatic wait_done(output int lat, output int busy_n);
      lat    = 0;
      busy_n = 0;
      while (lat < 20) begin
         @(negedge clock);
         if (done) break;
         if (busy) busy_n++;
         lat++;
      end
   endtask

   int lat, busy_n, ed, ebo, eov, done_seen;

   initial begin
      checks   = 0;
      failures = 0;
      reset    = 1'b1;
      start    = 1'b0;
      a        = '0;
      b        = '0;
      b_in     = 1'b0;

      vecs[0] = '{a: 4'd7, b: 4'd3,  bin: 1'b0, d: 4'd4,  bo: 1'b0, ov: 1'b0};
      vecs[1] = '{a: 4'd3, b: 4'd7,  bin: 1'b0, d: 4'd12, bo: 1'b1, ov: 1'b0};
      vecs[2] = '{a: 4'd0, b: 4'd0,  bin: 1'b1, d: 4'd15, bo: 1'b1, ov: 1'b0};
      vecs[3] = '{a: 4'd8, b: 4'd1,  bin: 1'b0, d: 4'd7,  bo: 1'b0, ov: 1'b1};
      vecs[4] = '{a: 4'd7, b: 4'd15, bin: 1'b0, d: 4'd8,  bo: 1'b1, ov: 1'b1};
      vecs[5] = '{a: 4'd0, b: 4'd15, bin: 1'b1, d: 4'd0,  bo: 1'b1, ov: 1'b0};

      // Reset state
      @(posedge clock);
      @(posedge clock);
      @(negedge clock);
      check("reset_d", d, 0);
      check("reset_b_out", b_out, 0);
      check("reset_overflow", overflow, 0);
      check("reset_busy", busy, 0);
      check("reset_done", done, 0);
      reset = 1'b0;

      // Directed table
      foreach (vecs[i]) begin
         start_op(vecs[i].a, vecs[i].b, vecs[i].bin);
         wait_done(lat, busy_n);
         check($sformatf("vec%0d_d", i), d, vecs[i].d);
         check($sformatf("vec%0d_b_out", i), b_out, vecs[i].bo);
         check($sformatf("vec%0d_overflow", i), overflow, vecs[i].ov);
         check($sformatf("vec%0d_latency", i), lat, WIDTH);
         check($sformatf("vec%0d_busy_cycles", i), busy_n, WIDTH);
         check($sformatf("vec%0d_busy_at_done", i), busy, 0);
         @(negedge clock);
         check($sformatf("vec%0d_done_one_cycle", i), done, 0);
         check($sformatf("vec%0d_d_held_idle", i), d, vecs[i].d);
      end

      // Operand changes and a start pulse during RUN are ignored
      start_op(4'd5, 4'd9, 1'b0);
      @(negedge clock);
      a     = 4'd0;
      b     = 4'd0;
      b_in  = 1'b1;
      start = 1'b1;
      @(negedge clock);
      start = 1'b0;
      a     = 4'd15;
      wait_done(lat, busy_n);
      model(5, 9, 0, ed, ebo, eov);
      check("run_ignore_d", d, ed);
      check("run_ignore_b_out", b_out, ebo);
      check("run_ignore_overflow", overflow, eov);
      check("run_ignore_latency", lat, WIDTH - 2);

      // Back-to-back with start held high through DONE
      @(posedge clock);
      #1;
      a     = 4'd1;
      b     = 4'd2;
      b_in  = 1'b0;
      start = 1'b1;
      @(posedge clock);
      #1;
      wait_done(lat, busy_n);
      model(1, 2, 0, ed, ebo, eov);
      check("b2b0_latency", lat, WIDTH);
      check("b2b0_d", d, ed);
      check("b2b0_b_out", b_out, ebo);
      a    = 4'd9;
      b    = 4'd4;
      b_in = 1'b1;
      @(negedge clock);
      check("b2b1_reload_busy", busy, 1);
      check("b2b1_d_held_run", d, ed);
      wait_done(lat, busy_n);
      model(9, 4, 1, ed, ebo, eov);
      check("b2b1_period", lat + 1, WIDTH);
      check("b2b1_d", d, ed);
      check("b2b1_b_out", b_out, ebo);
      check("b2b1_overflow", overflow, eov);
      a    = 4'd4;
      b    = 4'd9;
      b_in = 1'b0;
      wait_done(lat, busy_n);
      model(4, 9, 0, ed, ebo, eov);
      check("b2b2_period", lat, WIDTH);
      check("b2b2_d", d, ed);
      check("b2b2_b_out", b_out, ebo);
      check("b2b2_overflow", overflow, eov);
      start = 1'b0;
      @(negedge clock);
      check("b2b_end_done", done, 0);
      check("b2b_end_busy", busy, 0);
      check("b2b_end_d_held", d, ed);

      // Reset in the middle of RUN (cnt==2) abandons the operation
      start_op(4'd3, 4'd1, 1'b0);
      @(posedge clock);
      @(posedge clock);
      #1;
      reset = 1'b1;
      @(posedge clock);
      #1;
      reset = 1'b0;
      @(negedge clock);
      check("midrst_d", d, 0);
      check("midrst_b_out", b_out, 0);
      check("midrst_overflow", overflow, 0);
      check("midrst_busy", busy, 0);
      check("midrst_done", done, 0);
      done_seen = 0;
      for (int k = 0; k < 8; k++) begin
         @(negedge clock);
         if (done || busy) done_seen++;
      end
      check("midrst_no_done", done_seen, 0);
      start_op(4'd6, 4'd2, 1'b1);
      wait_done(lat, busy_n);
      check("midrst_next_d", d, 3);
      check("midrst_next_b_out", b_out, 0);
      check("midrst_next_latency", lat, WIDTH);

      // Full operand sweep against the reference model
      for (int ai = 0; ai < 16; ai++) begin
         for (int bi = 0; bi < 16; bi++) begin
            for (int ci = 0; ci < 2; ci++) begin
               start_op(4'(ai), 4'(bi), 1'(ci));
               wait_done(lat, busy_n);
               model(ai, bi, ci, ed, ebo, eov);
               check($sformatf("sweep_%0d_%0d_%0d_d", ai, bi, ci), d, ed);
               check($sformatf("sweep_%0d_%0d_%0d_b_out", ai, bi, ci), b_out, ebo);
               check($sformatf("sweep_%0d_%0d_%0d_overflow", ai, bi, ci), overflow, eov);
               check($sformatf("sweep_%0d_%0d_%0d_latency", ai, bi, ci), lat, WIDTH);
            end
         end
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
